// File: rtl/fetch_sequencer_pkg.sv
// ---------------------------------------------------------------
// fetch_sequencer_pkg : shared fetch types, widths and helpers
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package fetch_sequencer_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  localparam int LINE_BYTES = 16;
  localparam int LINE_OFF_W = 4;
  localparam int QLOAD_W    = 6;
  localparam int LINE_IDX_W = 32 - LINE_OFF_W;

  // 2-bit saturating step tables for the outstanding/drop counters.
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    logic [1:0] r;
    case (v)
      2'd0:    r = 2'd1;
      2'd1:    r = 2'd2;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] v);
    logic [1:0] r;
    case (v)
      2'd3:    r = 2'd2;
      2'd2:    r = 2'd1;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Ripple-carry line-index increment; natural wrap at 2^28.
  function automatic logic [LINE_IDX_W-1:0] inc_line(input logic [LINE_IDX_W-1:0] v);
    logic [LINE_IDX_W-1:0] r;
    logic                  c;
    c = 1'b1;
    for (int i = 0; i < LINE_IDX_W; i++) begin
      r[i] = v[i] ^ c;
      c    = v[i] & c;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_sat_updown_counter.sv
// ---------------------------------------------------------------
// sat_updown_counter : 2-bit inc/dec/load counter, saturating at 0
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module sat_updown_counter
  import fetch_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_load,
  input  logic [1:0] i_load_val,
  output logic [1:0] o_count
);

  logic [1:0] r_count;
  logic [1:0] w_next;

  // Load has priority; simultaneous inc and dec cancel.
  always_comb begin
    w_next = r_count;
    if (i_load)
      w_next = i_load_val;
    else if (i_inc && !i_dec)
      w_next = sat_inc2(r_count);
    else if (i_dec && !i_inc)
      w_next = sat_dec2(r_count);
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_count <= 2'd0;
    else
      r_count <= w_next;
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------
// fetch_sequencer : I-cache line request sequencer with redirect drain
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'hFFFF_FFF0,
  parameter int          MAX_OUT      = 2
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 redirect_i,
  input  logic [31:0]          redirect_addr_i,
  input  logic                 halt_i,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [31:0]          req_addr_o,
  input  logic                 resp_valid_i,
  output logic                 resp_ready_o,
  input  logic [127:0]         resp_data_i,
  output logic                 q_valid_o,
  input  logic                 q_ready_i,
  output logic [127:0]         q_data_o,
  output logic                 q_load_o,
  output logic [QLOAD_W-1:0]   q_load_address_o
);

  localparam logic [1:0] c_max_out = MAX_OUT[1:0];

  fetch_state_e          r_state;
  fetch_state_e          w_state_next;
  logic [LINE_IDX_W-1:0] r_fetch_addr;
  logic                  r_first;
  logic [1:0]            w_out_cnt;
  logic [1:0]            w_drop_cnt;
  logic [1:0]            w_drop_load;
  logic                  w_below_max;
  logic                  w_req_fire;
  logic                  w_resp_fire;
  logic                  w_boot_load;

  assign w_below_max = (w_out_cnt < c_max_out);
  assign req_valid_o = ~reset & ~halt_i & ~redirect_i & w_below_max;
  assign req_addr_o  = {r_fetch_addr, {LINE_OFF_W{1'b0}}};
  assign w_req_fire  = req_valid_o & req_ready_i;

  // Responses are swallowed while draining stale lines or during a redirect.
  assign resp_ready_o = redirect_i | (r_state == ST_DRAIN) | q_ready_i;
  assign w_resp_fire  = resp_valid_i & resp_ready_o;
  assign q_valid_o    = resp_valid_i & ~redirect_i & (r_state == ST_RUN);
  assign q_data_o     = resp_data_i;

  assign w_boot_load = r_first & ~reset;
  assign q_load_o    = ~reset & (redirect_i | r_first);

  always_comb begin
    q_load_address_o = '0;
    if (!reset && redirect_i)
      q_load_address_o = {2'b00, redirect_addr_i[LINE_OFF_W-1:0]};
    else if (w_boot_load)
      q_load_address_o = {2'b00, RESET_VECTOR[LINE_OFF_W-1:0]};
  end

  // Lines still owed by the I-cache after this cycle's response.
  assign w_drop_load = w_resp_fire ? sat_dec2(w_out_cnt) : w_out_cnt;

  sat_updown_counter u_out_cnt (
    .clk        (clk),
    .rst        (reset),
    .i_inc      (w_req_fire),
    .i_dec      (w_resp_fire),
    .i_load     (1'b0),
    .i_load_val (2'd0),
    .o_count    (w_out_cnt)
  );

  sat_updown_counter u_drop_cnt (
    .clk        (clk),
    .rst        (reset),
    .i_inc      (1'b0),
    .i_dec      (w_resp_fire & (r_state == ST_DRAIN)),
    .i_load     (redirect_i),
    .i_load_val (w_drop_load),
    .o_count    (w_drop_cnt)
  );

  always_comb begin
    w_state_next = r_state;
    if (redirect_i)
      w_state_next = (w_drop_load != 2'd0) ? ST_DRAIN : ST_RUN;
    else if (r_state == ST_DRAIN && w_resp_fire && w_drop_cnt <= 2'd1)
      w_state_next = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_fetch_addr <= RESET_VECTOR[31:LINE_OFF_W];
      r_first      <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_first <= 1'b0;
      if (redirect_i)
        r_fetch_addr <= redirect_addr_i[31:LINE_OFF_W];
      else if (w_req_fire)
        r_fetch_addr <= inc_line(r_fetch_addr);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------
// tb_fetch_sequencer : directed self-checking bench for fetch_sequencer
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_fetch_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         redirect_i;
  logic [31:0]  redirect_addr_i;
  logic         halt_i;
  logic         req_valid_o;
  logic         req_ready_i;
  logic [31:0]  req_addr_o;
  logic         resp_valid_i;
  logic         resp_ready_o;
  logic [127:0] resp_data_i;
  logic         q_valid_o;
  logic         q_ready_i;
  logic [127:0] q_data_o;
  logic         q_load_o;
  logic [5:0]   q_load_address_o;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_sequencer #(.RESET_VECTOR(32'hFFFF_FFF0), .MAX_OUT(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .redirect_i       (redirect_i),
    .redirect_addr_i  (redirect_addr_i),
    .halt_i           (halt_i),
    .req_valid_o      (req_valid_o),
    .req_ready_i      (req_ready_i),
    .req_addr_o       (req_addr_o),
    .resp_valid_i     (resp_valid_i),
    .resp_ready_o     (resp_ready_o),
    .resp_data_i      (resp_data_i),
    .q_valid_o        (q_valid_o),
    .q_ready_i        (q_ready_i),
    .q_data_o         (q_data_o),
    .q_load_o         (q_load_o),
    .q_load_address_o (q_load_address_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  localparam logic [127:0] D_A = {4{32'hAAAA_0001}};
  localparam logic [127:0] D_C = {4{32'hCCCC_0003}};
  localparam logic [127:0] D_E = {4{32'hEEEE_0005}};
  localparam logic [127:0] D_I = {4{32'h1111_0009}};

  initial begin
    reset = 1; redirect_i = 0; redirect_addr_i = 0; halt_i = 0;
    req_ready_i = 0; resp_valid_i = 0; resp_data_i = '0; q_ready_i = 1;

    // Reset and wrap of the first two requests
    tick(); tick();
    check("rst_req_valid", req_valid_o, 1'b0);
    check("rst_q_load", q_load_o, 1'b0);
    reset = 0; req_ready_i = 1; settle();
    check("boot_q_load", q_load_o, 1'b1);
    check("boot_q_load_addr", q_load_address_o, 6'h00);
    check("boot_req_valid", req_valid_o, 1'b1);
    check("boot_req_addr", req_addr_o, 32'hFFFF_FFF0);
    tick();
    check("wrap_q_load", q_load_o, 1'b0);
    check("wrap_req_addr", req_addr_o, 32'h0000_0000);
    check("wrap_req_valid", req_valid_o, 1'b1);
    tick();
    check("max_out_block", req_valid_o, 1'b0);

    // Redirect with two outstanding: both returns dropped
    redirect_i = 1; redirect_addr_i = 32'h0000_1234; req_ready_i = 0; settle();
    check("rd1_q_load", q_load_o, 1'b1);
    check("rd1_q_load_addr", q_load_address_o, 6'h04);
    check("rd1_req_valid", req_valid_o, 1'b0);
    check("rd1_resp_ready", resp_ready_o, 1'b1);
    tick();
    redirect_i = 0; resp_valid_i = 1; resp_data_i = D_A; settle();
    check("drain1_q_valid", q_valid_o, 1'b0);
    check("drain1_resp_ready", resp_ready_o, 1'b1);
    check("drain1_q_load", q_load_o, 1'b0);
    tick();
    check("drain2_q_valid", q_valid_o, 1'b0);
    check("drain2_req_valid", req_valid_o, 1'b1);
    check("drain2_req_addr", req_addr_o, 32'h0000_1230);
    tick();
    resp_valid_i = 0; q_ready_i = 0; settle();
    check("run_resp_ready_follows_q", resp_ready_o, 1'b0);
    q_ready_i = 1; req_ready_i = 1; settle();
    check("run_req_addr", req_addr_o, 32'h0000_1230);

    // Queue back-pressure in RUN
    tick();
    req_ready_i = 0; resp_valid_i = 1; resp_data_i = D_C; q_ready_i = 0; settle();
    check("bp_resp_ready", resp_ready_o, 1'b0);
    check("bp_q_valid", q_valid_o, 1'b1);
    check("bp_req_addr", req_addr_o, 32'h0000_1240);
    tick();
    check("bp_hold_req_valid", req_valid_o, 1'b1);
    q_ready_i = 1; settle();
    check("bp_release_resp_ready", resp_ready_o, 1'b1);
    check("bp_release_q_data", q_data_o, D_C);

    // Redirect coinciding with the last outstanding response
    tick();
    resp_valid_i = 0; req_ready_i = 1; settle();
    check("r40_req_addr", req_addr_o, 32'h0000_1240);
    tick();
    req_ready_i = 0; redirect_i = 1; redirect_addr_i = 32'h0000_2008;
    resp_valid_i = 1; resp_data_i = D_E; settle();
    check("r40_q_valid", q_valid_o, 1'b0);
    check("r40_resp_ready", resp_ready_o, 1'b1);
    check("r40_q_load_addr", q_load_address_o, 6'h08);
    tick();
    redirect_i = 0; resp_valid_i = 0; q_ready_i = 0; settle();
    check("r40_stays_run", resp_ready_o, 1'b0);
    check("r40_req_addr_after", req_addr_o, 32'h0000_2000);
    req_ready_i = 1; settle();
    tick();
    req_ready_i = 0; q_ready_i = 1; resp_valid_i = 1; resp_data_i = D_E; settle();
    check("r40_deliver_valid", q_valid_o, 1'b1);
    check("r40_deliver_data", q_data_o, D_E);

    // Halt for five cycles with a redirect inside it
    tick();
    resp_valid_i = 0; halt_i = 1; req_ready_i = 1;
    for (int i = 0; i < 5; i++) begin
      redirect_i = (i == 1); redirect_addr_i = 32'h0000_0040; settle();
      check("halt_req_valid", req_valid_o, 1'b0);
      check("halt_q_load", q_load_o, (i == 1));
      tick();
    end
    redirect_i = 0; halt_i = 0; settle();
    check("halt_release_valid", req_valid_o, 1'b1);
    check("halt_release_addr", req_addr_o, 32'h0000_0040);

    // Second redirect during DRAIN reloads the drop count
    tick();
    check("r43_req_addr", req_addr_o, 32'h0000_0050);
    tick();
    req_ready_i = 0; redirect_i = 1; redirect_addr_i = 32'h0000_0100; settle();
    check("r43_rd1_q_load", q_load_o, 1'b1);
    tick();
    redirect_i = 0; resp_valid_i = 1; resp_data_i = D_A; settle();
    check("r43_drop1", q_valid_o, 1'b0);
    tick();
    resp_valid_i = 0; req_ready_i = 1; settle();
    check("r43_req_in_drain", req_addr_o, 32'h0000_0100);
    tick();
    req_ready_i = 0; redirect_i = 1; redirect_addr_i = 32'h0000_0200; settle();
    check("r43_rd2_q_load_addr", q_load_address_o, 6'h00);
    tick();
    redirect_i = 0; resp_valid_i = 1; resp_data_i = D_C; settle();
    check("r43_drop2", q_valid_o, 1'b0);
    tick();
    check("r43_drop3", q_valid_o, 1'b0);
    check("r43_drop3_ready", resp_ready_o, 1'b1);
    tick();
    resp_valid_i = 0; req_ready_i = 1; settle();
    check("r43_new_req_addr", req_addr_o, 32'h0000_0200);
    tick();
    req_ready_i = 0; resp_valid_i = 1; resp_data_i = D_I; settle();
    check("r43_deliver_valid", q_valid_o, 1'b1);
    check("r43_deliver_data", q_data_o, D_I);

    // Reset mid-operation with one request outstanding
    tick();
    resp_valid_i = 0; req_ready_i = 1;
    tick();
    reset = 1; settle();
    check("mid_rst_req_valid", req_valid_o, 1'b0);
    tick();
    reset = 0; settle();
    check("mid_rst_q_load", q_load_o, 1'b1);
    check("mid_rst_req_addr", req_addr_o, 32'hFFFF_FFF0);
    tick();
    check("mid_rst_cnt_cleared", req_valid_o, 1'b1);
    tick();
    check("mid_rst_max_out", req_valid_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
